// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: PC sequencing, single-outstanding imem requests, {word,pc} buffer to decode.
// Latency: request accepted in N, response in N+k, instruction_valid in N+k+1.
// Backpressure: requests stop while the buffer is full; a redirect flushes buffer and in-flight word.

module ifu_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push_vld,
    input  logic [WIDTH-1:0]             push_dat,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage is cleared on reset so the head fields are never X.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_vld && !pop) begin
                count <= count + 1'b1;
            end else if (!push_vld && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    assign head_dat = mem[rd_ptr];
endmodule

module instruction_fetch_unit #(
    parameter logic [31:0] RESET_ADDRESS = 32'h0000_0000,
    parameter int          DEPTH         = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_request,
    output logic [31:0] imem_address,
    input  logic        imem_ready,
    input  logic        imem_response_valid,
    input  logic [31:0] imem_response_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_address,
    output logic        instruction_valid,
    output logic [31:0] instruction,
    output logic [31:0] instruction_pc,
    input  logic        decode_ready
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {REQUEST, WAIT, DISCARD} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

    state_t        state;
    state_t        state_nxt;
    logic [31:0]   fetch_pc;
    logic [31:0]   request_pc;
    logic [CW-1:0] count;
    logic          req_fire;
    logic          push_vld;
    logic          pop;
    fetch_entry_t  push_dat;
    fetch_entry_t  head_dat;

    assign imem_request = !reset && (state == REQUEST) && (count < DEPTH_C) && !redirect_valid;
    assign imem_address = fetch_pc;
    assign req_fire     = imem_request && imem_ready;

    assign push_vld      = (state == WAIT) && imem_response_valid && !redirect_valid;
    assign push_dat.pc   = request_pc;
    assign push_dat.word = imem_response_data;
    assign pop           = instruction_valid && decode_ready && !redirect_valid;

    // A redirect while REQUEST needs no special case: the request is already masked.
    always_comb begin
        state_nxt = state;
        case (state)
            REQUEST: if (req_fire) state_nxt = WAIT;
            WAIT: begin
                if (imem_response_valid) begin
                    state_nxt = REQUEST;
                end else if (redirect_valid) begin
                    state_nxt = DISCARD;
                end
            end
            DISCARD: if (imem_response_valid) state_nxt = REQUEST;
            default: state_nxt = REQUEST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= REQUEST;
            fetch_pc   <= RESET_ADDRESS;
            request_pc <= RESET_ADDRESS;
        end else begin
            state <= state_nxt;
            if (redirect_valid) begin
                fetch_pc <= {redirect_address[31:2], 2'b00};
            end else if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (req_fire) begin
                request_pc <= fetch_pc;
            end
        end
    end

    ifu_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect_valid),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head_dat),
        .count    (count)
    );

    assign instruction_valid = (count != '0);
    assign instruction       = head_dat.word;
    assign instruction_pc    = head_dat.pc;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a behavioural memory responds with addr ^ 32'h0BAD_0000.
module tb_instruction_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        imem_request;
    logic [31:0] imem_address;
    logic        imem_ready;
    logic        imem_response_valid;
    logic [31:0] imem_response_data;
    logic        redirect_valid;
    logic [31:0] redirect_address;
    logic        instruction_valid;
    logic [31:0] instruction;
    logic [31:0] instruction_pc;
    logic        decode_ready;

    logic        d2_imem_request;
    logic [31:0] d2_imem_address;
    logic        d2_instruction_valid;
    logic [31:0] d2_instruction;
    logic [31:0] d2_instruction_pc;

    int vectors = 0;
    int miscompares = 0;
    int mem_lat = 1;
    int hs_cnt = 0;
    int hs_base;

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk                 (clk),
        .reset               (reset),
        .imem_request        (imem_request),
        .imem_address        (imem_address),
        .imem_ready          (imem_ready),
        .imem_response_valid (imem_response_valid),
        .imem_response_data  (imem_response_data),
        .redirect_valid      (redirect_valid),
        .redirect_address    (redirect_address),
        .instruction_valid   (instruction_valid),
        .instruction         (instruction),
        .instruction_pc      (instruction_pc),
        .decode_ready        (decode_ready)
    );

    instruction_fetch_unit #(.RESET_ADDRESS(32'hFFFF_FFFC)) dut_wrap (
        .clk                 (clk),
        .reset               (reset),
        .imem_request        (d2_imem_request),
        .imem_address        (d2_imem_address),
        .imem_ready          (imem_ready),
        .imem_response_valid (imem_response_valid),
        .imem_response_data  (imem_response_data),
        .redirect_valid      (redirect_valid),
        .redirect_address    (redirect_address),
        .instruction_valid   (d2_instruction_valid),
        .instruction         (d2_instruction),
        .instruction_pc      (d2_instruction_pc),
        .decode_ready        (decode_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Memory: samples the handshake mid-cycle, answers after mem_lat cycles for one cycle.
    initial begin
        logic [31:0] a;
        imem_response_valid = 1'b0;
        imem_response_data  = '0;
        forever begin
            @(negedge clk);
            if (!reset && imem_request && imem_ready) begin
                hs_cnt++;
                a = imem_address;
                @(posedge clk);
                #1;
                repeat (mem_lat - 1) begin
                    @(posedge clk);
                    #1;
                end
                imem_response_valid = 1'b1;
                imem_response_data  = a ^ 32'h0BAD_0000;
                @(posedge clk);
                #1;
                imem_response_valid = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset            = 1'b1;
        imem_ready       = 1'b1;
        decode_ready     = 1'b1;
        redirect_valid   = 1'b0;
        redirect_address = '0;
        repeat (3) step();
        #1;
        chk("rst_req", {31'd0, imem_request}, 32'd0);
        chk("rst_valid", {31'd0, instruction_valid}, 32'd0);
        chk("rst_instr", instruction, 32'd0);
        chk("rst_pc", instruction_pc, 32'd0);

        // Reset release: first request at RESET_ADDRESS in the same cycle.
        reset = 1'b0;
        #1;
        chk("first_req", {31'd0, imem_request}, 32'd1);
        chk("first_addr", imem_address, 32'h0000_0000);
        chk("wrap_addr0", d2_imem_address, 32'hFFFF_FFFC);
        step(); #1;
        chk("lat_valid_d1", {31'd0, instruction_valid}, 32'd0);
        chk("wait_no_req", {31'd0, imem_request}, 32'd0);
        step(); #1;
        chk("lat_valid_d2", {31'd0, instruction_valid}, 32'd1);
        chk("pc0", instruction_pc, 32'h0000_0000);
        chk("word0", instruction, 32'h0BAD_0000);
        chk("addr4", imem_address, 32'h0000_0004);
        chk("wrap_addr1", d2_imem_address, 32'h0000_0000);
        step(); step(); #1;
        chk("pc4", instruction_pc, 32'h0000_0004);
        chk("word4", instruction, 32'h0BAD_0004);
        step(); step(); #1;
        chk("pc8", instruction_pc, 32'h0000_0008);
        chk("word8", instruction, 32'h0BAD_0008);

        // Reset mid-operation, then imem_ready low for three cycles.
        reset = 1'b1;
        #1;
        chk("midrst_req", {31'd0, imem_request}, 32'd0);
        step();
        reset      = 1'b0;
        imem_ready = 1'b0;
        hs_base    = hs_cnt;
        #1;
        chk("midrst_valid", {31'd0, instruction_valid}, 32'd0);
        chk("midrst_pc", instruction_pc, 32'd0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                step(); #1;
            end
            chk("stall_req", {31'd0, imem_request}, 32'd1);
            chk("stall_addr", imem_address, 32'h0000_0000);
        end
        step();
        imem_ready = 1'b1;
        #1;
        chk("stall_req_acc", {31'd0, imem_request}, 32'd1);
        step(); #1;
        chk("stall_wait", {31'd0, imem_request}, 32'd0);
        step();
        decode_ready = 1'b0;
        #1;
        chk("stall_hs_once", hs_cnt - hs_base, 32'd1);
        chk("stall_pc0", instruction_pc, 32'h0000_0000);

        // Backpressure: two fills with DEPTH=2 then requests stop.
        step(); step(); #1;
        chk("full_req", {31'd0, imem_request}, 32'd0);
        chk("full_head", instruction_pc, 32'h0000_0000);
        step();
        decode_ready = 1'b1;
        #1;
        chk("full_req2", {31'd0, imem_request}, 32'd0);
        chk("full_head2", instruction_pc, 32'h0000_0000);
        step();
        decode_ready = 1'b0;
        #1;
        chk("pop_head", instruction_pc, 32'h0000_0004);
        chk("pop_req", {31'd0, imem_request}, 32'd1);
        chk("pop_addr", imem_address, 32'h0000_0008);

        // Redirect during WAIT, response two cycles later.
        step(); step();
        decode_ready = 1'b1;
        mem_lat      = 3;
        step(); step();
        redirect_valid   = 1'b1;
        redirect_address = 32'h0000_0103;
        #1;
        chk("redir_mask", {31'd0, imem_request}, 32'd0);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("redir_flush", {31'd0, instruction_valid}, 32'd0);
        chk("discard_req", {31'd0, imem_request}, 32'd0);
        step();
        mem_lat = 1;
        #1;
        chk("discard_resp", {31'd0, imem_response_valid}, 32'd1);
        chk("discard_req2", {31'd0, imem_request}, 32'd0);
        step(); #1;
        chk("drop_empty", {31'd0, instruction_valid}, 32'd0);
        chk("redir_addr", imem_address, 32'h0000_0100);
        chk("redir_req", {31'd0, imem_request}, 32'd1);
        step(); step();
        decode_ready = 1'b0;
        #1;
        chk("redir_pc", instruction_pc, 32'h0000_0100);
        chk("redir_word", instruction, 32'h0BAD_0100);

        // Redirect colliding with a response and a pending pop.
        step();
        decode_ready     = 1'b1;
        redirect_valid   = 1'b1;
        redirect_address = 32'h0000_0200;
        #1;
        chk("coll_resp", {31'd0, imem_response_valid}, 32'd1);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("coll_empty", {31'd0, instruction_valid}, 32'd0);
        chk("coll_req", {31'd0, imem_request}, 32'd1);
        chk("coll_addr", imem_address, 32'h0000_0200);
        step(); step(); #1;
        chk("coll_pc", instruction_pc, 32'h0000_0200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

- Front-end stage that produces the 32-bit instruction word consumed by the instruction decoder.
- Holds the fetch PC and issues word requests to instruction memory over a valid/ready request channel, one request outstanding at a time.
- Buffers returned words with their PCs in a small FIFO and presents them to decode over a valid/ready handshake.
- Accepts redirects from execute (taken branch, jump, trap) and flushes all in-flight and buffered instructions.

## Interface
- `RESET_ADDRESS`, default 32'h0000_0000: fetch PC after reset. Bits [1:0] must be 0.
- `DEPTH`, default 2: instruction buffer entries. Power of two, ≥ 2.

- `clk`  in  1  sole clock; everything is rising-edge.
- `reset`  in  1  synchronous, active-high.
- `imem_request`  out  1  request valid.
- `imem_address`  out  32  word address of the request; bits [1:0] are always 0.
- `imem_ready`  in  1  memory accepts the request this cycle.
- `imem_response_valid`  in  1  response data valid.
- `imem_response_data`  in  32  instruction word.
- `redirect_valid`  in  1  PC redirect request.
- `redirect_address`  in  32  new fetch PC; bits [1:0] are ignored and forced to 0.
- `instruction_valid`  out  1  buffer head valid.
- `instruction`  out  32  head instruction word.
- `instruction_pc`  out  32  PC of the head instruction.
- `decode_ready`  in  1  decode consumes the head this cycle.

## Operation
- State:
  - `fetch_pc` (32 bits).
  - `request_pc` (PC of the outstanding request).
  - FIFO of {word, pc} entries with `count` (0..DEPTH).
  - FSM with states REQUEST, WAIT and DISCARD.
- `imem_request` = !reset && state==REQUEST && count<DEPTH && !redirect_valid. This is combinational from registered state plus `redirect_valid`.
- `imem_address` = `fetch_pc`. It is held stable while `imem_request` is high and not accepted.
- Request handshake fires when `imem_request` && `imem_ready`:
  - `request_pc` <= `fetch_pc`.
  - `fetch_pc` <= `fetch_pc` + 4, wrapping modulo 2^32 (32'hFFFF_FFFC → 0).
  - Next state WAIT.
- WAIT, `imem_response_valid` without redirect: push {data, `request_pc`}, next state REQUEST.
  - No slot check is needed, because a request is only issued when count<DEPTH.
- Pop when `instruction_valid` && `decode_ready` && !`redirect_valid`.
- Push and pop in the same cycle are both performed; `count` is unchanged.
- Redirect (priority over everything else):
  - FIFO is flushed: `count` <= 0, and any same-cycle pop is not performed.
  - `fetch_pc` <= {`redirect_address`[31:2], 2'b00}.
  - Next state by current state:
    - REQUEST → REQUEST (no handshake can fire, because the request is masked).
    - WAIT with `imem_response_valid` → REQUEST, and the response is dropped.
    - WAIT without a response → DISCARD.
    - DISCARD with `imem_response_valid` → REQUEST.
    - DISCARD without a response → DISCARD.
- DISCARD without redirect: on `imem_response_valid`, drop the data and go to REQUEST. Otherwise stay in DISCARD.
- Responses arriving in REQUEST state are ignored.
- `instruction_valid` = (count != 0). `instruction` and `instruction_pc` come from the FIFO head.
  - They are don't-care when not valid, but must not be X after reset.
  - Head fields are stable while valid and not popped.
- Reset values:
  - `fetch_pc` = RESET_ADDRESS; `request_pc` = RESET_ADDRESS.
  - count = 0; FIFO pointers = 0; state = REQUEST.
  - `imem_request` = 0 while `reset` is high.
  - `instruction_valid` = 0; `instruction` = 0; `instruction_pc` = 0.
- Reset mid-operation (including in WAIT or DISCARD) returns to these values. The memory is reset on the same `reset`, so no stale response is expected.

## Timing
- First request: `imem_request`=1 with `imem_address`=RESET_ADDRESS in the first cycle after `reset` deasserts.
- Latency: request accepted in cycle N, response in cycle N+k (k ≥ 1), `instruction_valid` in cycle N+k+1.
- Next request asserts in cycle N+k+1. With k=1 and no stall, peak throughput is one instruction per 2 cycles.
- Redirect in cycle R:
  - `instruction_valid`=0 in R+1.
  - The earliest request to the new address is in R+1, or after the outstanding response is discarded.
- Backpressure: with `decode_ready`=0, the FIFO fills to DEPTH and `imem_request` then stays 0 until a pop.
  - A pop in cycle P allows a request in P+1.

## Test plan
- Reset release, memory with 1-cycle latency, `decode_ready`=1:
  - Addresses issued are 0, 4, 8, …
  - `instruction_pc`=0, 4, 8 with matching words.
  - `instruction_valid` first rises 3 cycles after reset deassertion.
- `imem_ready` low for 3 cycles on the first request: `imem_request` stays 1 and `imem_address` stays 0 throughout; exactly one handshake occurs.
- `decode_ready`=0 with DEPTH=2:
  - After 2 fills, `imem_request`=0 and the head stays pc=0.
  - Raise `decode_ready` for 1 cycle: pc=4 becomes head and one new request (address 8) is issued next cycle.
- Redirect to 32'h0000_0103 while in WAIT, response arriving 2 cycles later:
  - The response is dropped and the FIFO is empty next cycle.
  - The next request address is 32'h0000_0100, and the first instruction after redirect has `instruction_pc`=0x100.
- Redirect in the same cycle as `imem_response_valid` and a pending pop: the word is not pushed, `count`=0 next cycle, and the FSM returns to REQUEST.
- RESET_ADDRESS=32'hFFFF_FFFC: the second request address wraps to 32'h0000_0000.
